// File: rtl/ram_dma_pkg.sv
// Shared types and memory-map constants for the RAM-to-RAM word copy engine.
package ram_dma_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COPY,
        S_DRAIN,
        S_DONE
    } dma_state_e;

    localparam int IMEM_WORDS     = 512;
    localparam int DMEM_BASE_WORD = 512;
    localparam int MEM_WORDS      = 1024;
    localparam int LEN_W          = 11;
    // Word-index sums are one bit wider than LEN_W so start+len never wraps.
    localparam int WSUM_W         = 12;

endpackage

// File: rtl/dma_range_chk.sv
// Combinational legality check of a latched transfer request (alignment,
// source/destination ranges, overlap).
module dma_range_chk
    import ram_dma_pkg::*;
(
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             err_o,
    output logic             zero_len_o
);

    logic [WSUM_W-1:0] src_lo, src_hi, dst_lo, dst_hi;
    logic              misalign, src_oob, dst_oob, overlap;

    always_comb begin
        misalign   = (|src_i[1:0]) | (|dst_i[1:0]);
        zero_len_o = (len_i == '0);
        // Any address bit above the 1024-word map rules the range out before
        // the narrow sums are even looked at.
        src_lo     = {2'b00, src_i[11:2]};
        dst_lo     = {2'b00, dst_i[11:2]};
        src_hi     = src_lo + {1'b0, len_i};
        dst_hi     = dst_lo + {1'b0, len_i};
        src_oob    = (|src_i[31:12]) | (src_hi > WSUM_W'(MEM_WORDS));
        dst_oob    = (|dst_i[31:12]) | (dst_lo < WSUM_W'(DMEM_BASE_WORD))
                   | (dst_hi > WSUM_W'(MEM_WORDS));
        overlap    = !zero_len_o && (src_lo < dst_hi) && (dst_lo < src_hi);
        err_o      = misalign | src_oob | dst_oob | overlap;
    end

endmodule

// File: rtl/ram_dma.sv
// Single-channel word copy engine: reads src+4*i and writes dst+4*i one cycle
// later, streaming one word per cycle through the RAM master port.
module ram_dma
    import ram_dma_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             aborted_o,
    output logic [LEN_W-1:0] count_o,
    output logic [31:0]      ram_raddr_o,
    output logic [31:0]      ram_waddr_o,
    output logic [31:0]      ram_wdata_o,
    output logic             ram_cs_o,
    output logic             ram_re_o,
    output logic             ram_we_o,
    input  logic [31:0]      ram_rdata_i
);

    dma_state_e       state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0] len_q, len_d, count_q, count_d, idx_q, idx_d;
    logic [31:0]      raddr_q, raddr_d, waddr_q, waddr_d;
    logic             re_q, re_d, we_q, we_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d, ab_q, ab_d;
    logic             chk_err, chk_zero;

    dma_range_chk u_chk (
        .src_i      (src_q),
        .dst_i      (dst_q),
        .len_i      (len_q),
        .err_o      (chk_err),
        .zero_len_o (chk_zero)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        count_d = count_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        raddr_d = '0;
        waddr_d = '0;
        re_d    = 1'b0;
        we_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        ab_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    src_d   = src_addr_i;
                    dst_d   = dst_addr_i;
                    len_d   = len_i;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (abort_i || chk_err || chk_zero) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    ab_d    = abort_i;
                    err_d   = !abort_i && chk_err;
                end else begin
                    state_d = S_COPY;
                    re_d    = 1'b1;
                    raddr_d = src_q;
                    idx_d   = '0;
                end
            end
            S_COPY: begin
                if (abort_i) begin
                    // The write for the read on the bus right now is dropped.
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    ab_d    = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = dst_q + {{(32-LEN_W-2){1'b0}}, idx_q, 2'b00};
                    count_d = (count_q < len_q) ? count_q + LEN_W'(1) : count_q;
                    if (idx_q == len_q - LEN_W'(1)) begin
                        state_d = S_DRAIN;
                    end else begin
                        re_d    = 1'b1;
                        raddr_d = raddr_q + 32'd4;
                        idx_d   = idx_q + LEN_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                ab_d    = abort_i;
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            idx_q   <= '0;
            raddr_q <= '0;
            waddr_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ab_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            raddr_q <= raddr_d;
            waddr_q <= waddr_d;
            re_q    <= re_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ab_q    <= ab_d;
        end
    end

    // Read data lands the cycle after its read, exactly when its write issues.
    assign ram_wdata_o = we_q ? ram_rdata_i : '0;
    assign ram_raddr_o = raddr_q;
    assign ram_waddr_o = waddr_q;
    assign ram_re_o    = re_q;
    assign ram_we_o    = we_q;
    assign ram_cs_o    = re_q | we_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign aborted_o   = ab_q;
    assign count_o     = count_q;

endmodule

// File: tb/tb_ram_dma.sv
// Bench for ram_dma: RAM model plus a cycle-timing and memory-content model.
module tb_ram_dma;

    logic        clk = 1'b0;
    logic        rst_ni, start_i, abort_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [10:0] len_i;
    logic        busy_o, done_o, err_o, aborted_o;
    logic [10:0] count_o;
    logic [31:0] ram_raddr_o, ram_waddr_o, ram_wdata_o;
    logic        ram_cs_o, ram_re_o, ram_we_o;
    logic [31:0] ram_rdata = '0;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];
    logic        fill_en = 1'b0;
    logic        bad_wr  = 1'b0;
    int          nchecks = 0;
    int          nerr    = 0;

    always #5 clk = ~clk;

    ram_dma dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .src_addr_i  (src_addr_i),
        .dst_addr_i  (dst_addr_i),
        .len_i       (len_i),
        .abort_i     (abort_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .aborted_o   (aborted_o),
        .count_o     (count_o),
        .ram_raddr_o (ram_raddr_o),
        .ram_waddr_o (ram_waddr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_cs_o    (ram_cs_o),
        .ram_re_o    (ram_re_o),
        .ram_we_o    (ram_we_o),
        .ram_rdata_i (ram_rdata)
    );

    // Synchronous RAM: read data after the edge, write commits at the edge,
    // same-edge read sees old contents; writes outside dmem are flagged.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 1024; i++) mem[i] <= $urandom;
        end else begin
            if (ram_cs_o && ram_re_o)
                ram_rdata <= (ram_raddr_o[31:12] == '0) ? mem[ram_raddr_o[11:2]] : 32'hDEAD_BEEF;
            if (ram_cs_o && ram_we_o) begin
                if (ram_waddr_o[31:12] == '0 && ram_waddr_o[11]) mem[ram_waddr_o[11:2]] <= ram_wdata_o;
                else bad_wr <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_error(input logic [31:0] s, input logic [31:0] d, input int n);
        longint sw, dw;
        sw = s / 4;
        dw = d / 4;
        if (s % 4 != 0 || d % 4 != 0) return 1'b1;
        if (sw + n > 1024) return 1'b1;
        if (dw < 512 || dw + n > 1024) return 1'b1;
        if (n > 0 && sw < dw + n && dw < sw + n) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mem_check(input string tag);
        int mm;
        mm = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mm++;
        check(tag, 128'(mm), 128'(0));
        check("no_imem_write", 128'(bad_wr), 128'(0));
    endtask

    // One transfer starting at cycle 0; abort_at/rst_at = 0 means never.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input int n,
                       input int abort_at, input int rst_at);
        bit e, ok, ab, rd, wr, dn, bz;
        int nom_done, done_cyc, lim, last_wr, nwr, endb, c_end, sw, dw;
        logic [127:0] xb;
        e        = exp_error(s, d, n);
        ok       = !e && (n > 0);
        nom_done = ok ? n + 3 : 2;
        ab       = (abort_at >= 1) && (abort_at < nom_done);
        done_cyc = ab ? abort_at + 1 : nom_done;
        if (rst_at > 0 && rst_at < done_cyc) done_cyc = -1;
        lim = 1 << 30;
        if (ab) lim = abort_at;
        if (rst_at > 0 && rst_at < lim) lim = rst_at;
        last_wr = (n + 2 < lim) ? n + 2 : lim;
        nwr     = (ok && last_wr > 2) ? last_wr - 2 : 0;
        endb    = (done_cyc > 0) ? done_cyc : rst_at;
        c_end   = endb + 3;
        sw      = int'(s >> 2);
        dw      = int'(d >> 2);
        for (int c = 0; c <= c_end; c++) begin
            // A second start while busy carries junk config that must not land.
            start_i    = (c == 0) || (c == 2);
            src_addr_i = (c == 0) ? s : $urandom;
            dst_addr_i = (c == 0) ? d : $urandom;
            len_i      = (c == 0) ? 11'(n) : 11'($urandom);
            abort_i    = (c == abort_at);
            rst_ni     = !(rst_at > 0 && c == rst_at);
            @(negedge clk);
            rd = ok && c >= 2 && c <= n + 1 && c <= lim;
            wr = ok && c >= 3 && c <= n + 2 && c <= lim;
            dn = (c == done_cyc);
            bz = (c >= 1) && (c <= endb);
            xb = {29'b0, rd, wr, rd | wr,
                  rd ? s + 32'(4 * (c - 2)) : 32'b0,
                  wr ? d + 32'(4 * (c - 3)) : 32'b0,
                  wr ? ref_mem[sw + c - 3] : 32'b0};
            check("bus", {29'b0, ram_re_o, ram_we_o, ram_cs_o, ram_raddr_o, ram_waddr_o, ram_wdata_o}, xb);
            check("status", {124'b0, done_o, busy_o, err_o, aborted_o},
                  {124'b0, dn, bz, dn && e && !ab, dn && ab});
            if (dn || (rst_at > 0 && c > rst_at))
                check("count", 128'(count_o), 128'(dn ? nwr : 0));
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        rst_ni  = 1'b1;
        for (int i = 0; i < nwr; i++) ref_mem[dw + i] = ref_mem[sw + i];
        mem_check("mem");
    endtask

    initial begin
        int sw, dw, n, ab;
        logic [31:0] s, d;
        rst_ni     = 1'b0;
        start_i    = 1'b0;
        abort_i    = 1'b0;
        src_addr_i = '0;
        dst_addr_i = '0;
        len_i      = '0;
        fill_en    = 1'b1;
        @(posedge clk);
        #1 fill_en = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        check("rst_bus", {29'b0, ram_re_o, ram_we_o, ram_cs_o, ram_raddr_o, ram_waddr_o, ram_wdata_o}, '0);
        check("rst_status", {113'b0, done_o, busy_o, err_o, aborted_o, count_o}, '0);
        ref_mem = mem;
        @(posedge clk);
        #1 start_i = 1'b0;
        rst_ni = 1'b1;

        run(32'h000, 32'h800, 4, 0, 0);
        run(32'h000, 32'h800, 0, 0, 0);
        run(32'h000, 32'h004, 4, 0, 0);
        run(32'h000, 32'h801, 4, 0, 0);
        run(32'h800, 32'h808, 4, 0, 0);
        run(32'h000, 32'h800, 1024, 0, 0);
        run(32'h000, 32'h800, 512, 0, 0);
        run(32'h040, 32'h900, 8, 5, 0);
        run(32'h080, 32'hA00, 8, 0, 4);
        run(32'h080, 32'hA00, 8, 0, 0);
        run(32'hFFFF_FFFC, 32'h800, 2, 0, 0);
        run(32'h7FC, 32'h800, 2, 0, 0);
        run(32'h100, 32'hC00, 3, 5, 0);
        run(32'h100, 32'hC00, 3, 6, 0);
        run(32'h200, 32'hD00, 5, 1, 0);

        for (int k = 0; k < 40; k++) begin
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 9) < 6) begin
                sw = $urandom_range(0, 499);
                dw = $urandom_range(512, 1010);
            end else begin
                sw = $urandom_range(0, 1023);
                dw = $urandom_range(400, 1023);
            end
            s = 32'(sw) << 2;
            d = 32'(dw) << 2;
            if ($urandom_range(0, 9) == 0) s[1:0] = 2'($urandom_range(1, 3));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 4) : 0;
            run(s, d, n, ab, 0);
        end

        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end

endmodule
